// File: rtl/pt2262_encoder_gen_if.sv
// pt2262_encoder_gen_if: start/busy/done handshake, word inputs and serial outputs of the PT2262 encoder
interface pt2262_encoder_gen_if #(
  parameter int N_ADDR = 8,
  parameter int N_DATA = 4
);
  localparam int DW = N_DATA > 0 ? N_DATA : 1;
  logic start, cont, busy, done, cod_o, sync, word_end;
  logic [2*N_ADDR-1:0] addr;
  logic [DW-1:0] data;
  modport master(output start, cont, addr, data, input busy, done, cod_o, sync, word_end);
  modport slave(input start, cont, addr, data, output busy, done, cod_o, sync, word_end);
endinterface

// File: rtl/pt2262_encoder_gen.sv
// pt2262_encoder_gen: serialises a tri-state address and binary data word into PT2262 pulse-width code plus sync
module pt2262_encoder_gen #(
  parameter int N_ADDR = 8,
  parameter int N_DATA = 4,
  parameter int CLK_DIV = 250,
  parameter int N_REPEAT = 4
) (
  input logic clk,
  input logic reset,
  pt2262_encoder_gen_if.slave bus
);
  localparam int N_BITS = N_ADDR + N_DATA;
  localparam int DW = N_DATA > 0 ? N_DATA : 1;
  localparam int NREP = N_REPEAT < 1 ? 1 : N_REPEAT;
  localparam int RW = $clog2(NREP + 1);
  localparam int IW = N_BITS > 1 ? $clog2(N_BITS) : 1;
  localparam int CW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, BIT, SYNC, DONE} state_t;
  state_t state;
  logic [CW-1:0] div_cnt;
  logic [6:0] a_cnt;
  logic [IW-1:0] bit_idx;
  logic [RW-1:0] words;
  logic [2*N_ADDR-1:0] addr_l;
  logic [DW-1:0] data_l;
  logic cont_l;
  logic [N_BITS-1:0] f_long, s_long;
  logic [4:0] a_nxt;
  logic tick, nxt_lvl, more;
  // each symbol is two 16-alpha halves; a half is either short-high (4H12L) or long-high (12H4L)
  for (genvar i = 0; i < N_BITS; i++) begin : g_sym
    if (i < N_ADDR) begin : g_a
      assign f_long[i] = addr_l[2*i+1 -: 2] == 2'b01;
      assign s_long[i] = addr_l[2*i+1 -: 2] != 2'b00;
    end else begin : g_d
      assign f_long[i] = data_l[i-N_ADDR];
      assign s_long[i] = data_l[i-N_ADDR];
    end
  end
  if (N_DATA == 0) begin : g_nodata
    logic unused_data;
    assign unused_data = ^data_l;
  end
  assign tick = div_cnt == CW'(CLK_DIV - 1);
  assign a_nxt = a_cnt[4:0] + 5'd1;
  assign nxt_lvl = a_nxt[3:0] < ((a_nxt[4] ? s_long[bit_idx] : f_long[bit_idx]) ? 4'd12 : 4'd4);
  // continuous mode follows the live cont level at word end; one-shot counts words
  assign more = cont_l ? bus.cont : (int'(words) + 1 < NREP);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      div_cnt <= '0;
      a_cnt <= '0;
      bit_idx <= '0;
      words <= '0;
      addr_l <= '0;
      data_l <= '0;
      cont_l <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.cod_o <= 1'b0;
      bus.sync <= 1'b0;
      bus.word_end <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.word_end <= state == SYNC && a_cnt == 7'd127 && div_cnt == CW'(CLK_DIV - 2);
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + 1'b1;
      case (state)
        IDLE:
          if (bus.start) begin
            addr_l <= bus.addr;
            data_l <= bus.data;
            cont_l <= bus.cont;
            bus.busy <= 1'b1;
            bus.cod_o <= 1'b1;
            a_cnt <= '0;
            bit_idx <= '0;
            words <= '0;
            state <= BIT;
          end
        BIT:
          if (tick) begin
            if (a_cnt == 7'd31) begin
              a_cnt <= '0;
              bus.cod_o <= 1'b1;
              if (bit_idx == IW'(N_BITS - 1)) begin
                state <= SYNC;
                bus.sync <= 1'b1;
              end else bit_idx <= bit_idx + 1'b1;
            end else begin
              a_cnt <= a_cnt + 7'd1;
              bus.cod_o <= nxt_lvl;
            end
          end
        SYNC:
          if (tick) begin
            if (a_cnt == 7'd127) begin
              a_cnt <= '0;
              bit_idx <= '0;
              bus.sync <= 1'b0;
              cont_l <= bus.cont;
              words <= words == RW'(NREP) ? words : words + 1'b1;
              state <= more ? BIT : DONE;
              bus.cod_o <= more;
              bus.busy <= more;
              bus.done <= ~more;
            end else begin
              a_cnt <= a_cnt + 7'd1;
              bus.cod_o <= a_cnt < 7'd3;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pt2262_encoder_gen.sv
// tb_pt2262_encoder_gen: directed checks of the PT2262 encoder against a segment-walking waveform model
module tb_pt2262_encoder_gen;
  logic clk, reset, start, cont, sel;
  logic [23:0] addr;
  logic [3:0] data;
  int n_cmp = 0, n_bad = 0;
  int busy_n, wave_err, sync_err, we_n, we_first, we_last, done_at;
  logic hist [0:8191];
  pt2262_encoder_gen_if #(.N_ADDR(8), .N_DATA(4)) b1();
  pt2262_encoder_gen_if #(.N_ADDR(12), .N_DATA(0)) b2();
  pt2262_encoder_gen #(.N_ADDR(8), .N_DATA(4), .CLK_DIV(4), .N_REPEAT(2)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  pt2262_encoder_gen #(.N_ADDR(12), .N_DATA(0), .CLK_DIV(2), .N_REPEAT(1)) dut2 (.clk(clk), .reset(reset), .bus(b2.slave));
  assign b1.start = start & ~sel;
  assign b1.cont = cont;
  assign b1.addr = addr[15:0];
  assign b1.data = data;
  assign b2.start = start & sel;
  assign b2.cont = cont;
  assign b2.addr = addr;
  assign b2.data = 1'b0;
  logic o_cod, o_sync, o_busy, o_done, o_we;
  logic [4:0] o_vec;
  assign o_cod = sel ? b2.cod_o : b1.cod_o;
  assign o_sync = sel ? b2.sync : b1.sync;
  assign o_busy = sel ? b2.busy : b1.busy;
  assign o_done = sel ? b2.done : b1.done;
  assign o_we = sel ? b2.word_end : b1.word_end;
  assign o_vec = {o_cod, o_sync, o_busy, o_done, o_we};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic logic ref_lvl(input int a, input logic [23:0] ad, input logic [7:0] d, input int na, input int nd);
    int seg [4];
    int s, p;
    logic lv;
    if (a >= (na + nd) * 32) return (a - (na + nd) * 32) < 4;
    s = a / 32;
    p = a % 32;
    if (s < na) begin
      case (ad[2*s +: 2])
        2'b00: seg = '{4, 12, 4, 12};
        2'b01: seg = '{12, 4, 12, 4};
        default: seg = '{4, 12, 12, 4};
      endcase
    end else seg = d[s-na] ? '{12, 4, 12, 4} : '{4, 12, 4, 12};
    lv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (p < seg[i]) return lv;
      p -= seg[i];
      lv = ~lv;
    end
    return 1'b0;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic go(input logic s, input logic c, input logic [23:0] a, input logic [3:0] d);
    sel = s;
    cont = c;
    addr = a;
    data = d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  // sample c is the cycle after start-edge k+c; at hook_c inputs are scrambled, a start is pulsed and cont drops
  task automatic capture(input int cdiv, input int na, input int nd, input logic [23:0] a, input logic [7:0] d,
                         input int hook_c, input int limit);
    int wl, aw;
    wl = ((na + nd) * 32 + 128) * cdiv;
    busy_n = 0; wave_err = 0; sync_err = 0; we_n = 0; we_first = -1; we_last = -1; done_at = -1;
    for (int c = 0; c < limit && done_at < 0; c++) begin
      if (c < 8192) hist[c] = o_cod;
      if (o_busy) begin
        busy_n++;
        aw = (c % wl) / cdiv;
        if (o_cod !== ref_lvl(aw, a, d, na, nd)) wave_err++;
        if (o_sync !== (aw >= (na + nd) * 32)) sync_err++;
      end
      if (o_we) begin
        we_n++;
        if (we_first < 0) we_first = c;
        we_last = c;
      end
      if (o_done) done_at = c;
      else begin
        if (c == hook_c) begin
          cont = 1'b0;
          addr = ~addr;
          data = ~data;
          start = 1'b1;
        end
        if (c == hook_c + 1) start = 1'b0;
        @(posedge clk); #1;
      end
    end
  endtask
  initial begin
    reset = 1'b1; start = 1'b0; cont = 1'b0; sel = 1'b0; addr = '0; data = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_outs_dut1", 32'(o_vec), 0);
    sel = 1'b1; #1;
    check("reset_outs_dut2", 32'(o_vec), 0);
    sel = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    go(1'b0, 1'b0, 24'h0, 4'h0);
    repeat (40) @(posedge clk); #1;
    check("busy_before_abort", 32'(o_busy), 1);
    #2 reset = 1'b1; #1;
    check("abort_outs", 32'(o_vec), 0);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_abort", 32'(o_vec), 0);
    go(1'b0, 1'b0, 24'h0, 4'h0);
    capture(4, 8, 4, 24'h0, 8'h0, 1, 10000);
    check("os_done_at", done_at, 4096);
    check("os_busy_cycles", busy_n, 4096);
    check("os_word_end_n", we_n, 2);
    check("os_word_end_1", we_first, 2047);
    check("os_word_end_2", we_last, 4095);
    check("os_wave_err", wave_err, 0);
    check("os_sync_err", sync_err, 0);
    check("os_c15_high", 32'(hist[15]), 1);
    check("os_c16_low", 32'(hist[16]), 0);
    check("os_c64_high", 32'(hist[64]), 1);
    check("os_sync_c1551_high", 32'(hist[1551]), 1);
    check("os_sync_c1552_low", 32'(hist[1552]), 0);
    check("os_word2_c2048_high", 32'(hist[2048]), 1);
    @(posedge clk); #1;
    check("os_done_one_cycle", 32'({o_busy, o_done}), 0);
    go(1'b0, 1'b0, 24'h0009, 4'b1010);
    capture(4, 8, 4, 24'h0009, 8'b1010, 1, 10000);
    check("sym_done_at", done_at, 4096);
    check("sym_wave_err", wave_err, 0);
    check("sym_sync_err", sync_err, 0);
    check("sym_d0_c47_high", 32'(hist[47]), 1);
    check("sym_d0_c48_low", 32'(hist[48]), 0);
    check("sym_f_c144_low", 32'(hist[144]), 0);
    check("sym_f_c239_high", 32'(hist[239]), 1);
    check("sym_f_c240_low", 32'(hist[240]), 0);
    check("sym_data0_c1040_low", 32'(hist[1040]), 0);
    check("sym_data1_c1199_high", 32'(hist[1199]), 1);
    check("sym_data1_c1200_low", 32'(hist[1200]), 0);
    check("sym_data3_c1455_high", 32'(hist[1455]), 1);
    check("sym_data3_c1456_low", 32'(hist[1456]), 0);
    @(posedge clk); #1;
    go(1'b0, 1'b0, 24'h00A5C3, 4'b0110);
    capture(4, 8, 4, 24'h00A5C3, 8'b0110, 1, 10000);
    check("latch_done_at", done_at, 4096);
    check("latch_wave_err", wave_err, 0);
    check("latch_c111_high", 32'(hist[111]), 1);
    check("latch_c112_low", 32'(hist[112]), 0);
    @(posedge clk); #1;
    go(1'b0, 1'b1, 24'h00C1F4, 4'b0101);
    capture(4, 8, 4, 24'h00C1F4, 8'b0101, 2 * 2048 + 100, 10000);
    check("cont_done_at", done_at, 6144);
    check("cont_busy_cycles", busy_n, 6144);
    check("cont_word_end_n", we_n, 3);
    check("cont_word_end_last", we_last, 6143);
    check("cont_wave_err", wave_err, 0);
    check("cont_sync_err", sync_err, 0);
    repeat (4) @(posedge clk); #1;
    check("cont_start_not_queued", 32'(o_busy), 0);
    go(1'b1, 1'b0, 24'h9A41B6, 4'h0);
    capture(2, 12, 0, 24'h9A41B6, 8'h0, 1, 3000);
    check("sweep_done_at", done_at, 1024);
    check("sweep_busy_cycles", busy_n, 1024);
    check("sweep_word_end_n", we_n, 1);
    check("sweep_word_end_at", we_first, 1023);
    check("sweep_wave_err", wave_err, 0);
    check("sweep_sync_err", sync_err, 0);
    check("sweep_c8_low", 32'(hist[8]), 0);
    check("sweep_c55_high", 32'(hist[55]), 1);
    check("sweep_c56_low", 32'(hist[56]), 0);
    check("sweep_sync_c768_high", 32'(hist[768]), 1);
    check("sweep_sync_c776_low", 32'(hist[776]), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
